// File: rtl/julia_pkg.sv
// julia_pkg: shared constants and state types for the Julia pixel pipeline
package julia_pkg;
   localparam int DEF_LCD_W   = 320;
   localparam int DEF_LCD_H   = 240;
   localparam int DEF_COORD_W = 32;
   localparam int FIX_SCALE   = 8192;
   localparam int DEF_START_X = -2 * FIX_SCALE;
   localparam int DEF_END_X   = 2 * FIX_SCALE;
   localparam int DEF_START_Y = -3 * FIX_SCALE / 2;
   localparam int DEF_END_Y   = 3 * FIX_SCALE / 2;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} top_state_t;
   typedef enum logic [1:0] {FREE, BUSY, COOL} slot_state_t;
endpackage

// File: rtl/julia_coord_gen.sv
// julia_coord_gen: raster col/row counters with wrapping fixed-point x/y accumulators
module julia_coord_gen import julia_pkg::*; #(
   parameter int LCD_W   = DEF_LCD_W,
   parameter int LCD_H   = DEF_LCD_H,
   parameter int COORD_W = DEF_COORD_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      step,
   input  logic signed [COORD_W-1:0] start_x,
   input  logic signed [COORD_W-1:0] start_y,
   input  logic signed [COORD_W-1:0] dx,
   input  logic signed [COORD_W-1:0] dy,
   output logic signed [COORD_W-1:0] cur_x,
   output logic signed [COORD_W-1:0] cur_y,
   output logic                      last_pixel
);
   logic [15:0] col, row;
   logic signed [COORD_W-1:0] sx, ddx, ddy;
   logic row_end;
   assign row_end    = col == 16'(LCD_W - 1);
   assign last_pixel = row_end && row == 16'(LCD_H - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         sx    <= '0;
         ddx   <= '0;
         ddy   <= '0;
         cur_x <= '0;
         cur_y <= '0;
      end else if (load) begin
         col   <= '0;
         row   <= '0;
         sx    <= start_x;
         ddx   <= dx;
         ddy   <= dy;
         cur_x <= start_x;
         cur_y <= start_y;
      end else if (step) begin
         col   <= row_end ? '0 : col + 1'b1;
         row   <= row_end ? row + 1'b1 : row;
         cur_x <= row_end ? sx : cur_x + ddx;
         cur_y <= row_end ? cur_y + ddy : cur_y;
      end
endmodule

// File: rtl/julia_pixel_scheduler.sv
// julia_pixel_scheduler: shares NUM_ENG Julia engines across the raster and
// streams colours back in raster order over a valid/ready port
module julia_pixel_scheduler import julia_pkg::*; #(
   parameter int NUM_ENG = 8,
   parameter int LCD_W   = DEF_LCD_W,
   parameter int LCD_H   = DEF_LCD_H,
   parameter int COORD_W = DEF_COORD_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_start,
   input  logic signed [COORD_W-1:0]   start_x,
   input  logic signed [COORD_W-1:0]   start_y,
   input  logic signed [COORD_W-1:0]   dx,
   input  logic signed [COORD_W-1:0]   dy,
   output logic                        busy,
   output logic                        frame_done,
   output logic [NUM_ENG-1:0]          eng_enable,
   output logic [NUM_ENG*COORD_W-1:0]  eng_x,
   output logic [NUM_ENG*COORD_W-1:0]  eng_y,
   input  logic [NUM_ENG-1:0]          eng_end,
   input  logic [NUM_ENG*16-1:0]       eng_color,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic [15:0]                 pix_color,
   output logic [15:0]                 pix_x,
   output logic [15:0]                 pix_y
);
   localparam int PW    = $clog2(NUM_ENG);
   localparam int TOTAL = LCD_W * LCD_H;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [PW-1:0] LAST_ENG = PW'(NUM_ENG - 1);
   top_state_t state;
   slot_state_t slot [NUM_ENG];
   logic [PW-1:0] disp_ptr, col_ptr;
   logic [CW-1:0] coll_cnt;
   logic [15:0] out_col, out_row, sel_color;
   logic signed [COORD_W-1:0] cur_x, cur_y;
   logic last_pixel, start_ok, disp, coll;
   assign start_ok = state == IDLE && frame_start;
   assign disp     = state == RUN && slot[disp_ptr] == FREE;
   // a finished engine is only drained when the output register can take its colour
   assign coll     = slot[col_ptr] == BUSY && eng_end[col_ptr] && (!pix_valid || pix_ready);
   always_comb begin
      sel_color = '0;
      for (int i = 0; i < NUM_ENG; i++)
         sel_color = col_ptr == PW'(i) ? eng_color[i*16 +: 16] : sel_color;
   end
   julia_coord_gen #(.LCD_W(LCD_W), .LCD_H(LCD_H), .COORD_W(COORD_W)) u_coord (
      .clk(clk), .rst_n(rst_n), .load(start_ok), .step(disp),
      .start_x(start_x), .start_y(start_y), .dx(dx), .dy(dy),
      .cur_x(cur_x), .cur_y(cur_y), .last_pixel(last_pixel)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         disp_ptr   <= '0;
         col_ptr    <= '0;
         coll_cnt   <= '0;
         out_col    <= '0;
         out_row    <= '0;
         for (int i = 0; i < NUM_ENG; i++) slot[i] <= FREE;
         eng_enable <= '0;
         eng_x      <= '0;
         eng_y      <= '0;
         pix_valid  <= 1'b0;
         pix_color  <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (frame_start) begin
               state    <= RUN;
               busy     <= 1'b1;
               disp_ptr <= '0;
               col_ptr  <= '0;
               coll_cnt <= '0;
               out_col  <= '0;
               out_row  <= '0;
            end
            RUN: if (disp && last_pixel) state <= DRAIN;
            DRAIN: if (coll_cnt == CW'(TOTAL) && (!pix_valid || pix_ready)) begin
               state      <= DONE;
               busy       <= 1'b0;
               frame_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         // COOL lasts one cycle so every engine sees enable low before reuse
         for (int i = 0; i < NUM_ENG; i++) begin
            if (slot[i] == COOL) slot[i] <= FREE;
            if (disp && disp_ptr == PW'(i)) begin
               slot[i]                    <= BUSY;
               eng_enable[i]              <= 1'b1;
               eng_x[i*COORD_W +: COORD_W] <= cur_x;
               eng_y[i*COORD_W +: COORD_W] <= cur_y;
            end
            if (coll && col_ptr == PW'(i)) begin
               slot[i]       <= COOL;
               eng_enable[i] <= 1'b0;
            end
         end
         if (disp) disp_ptr <= disp_ptr == LAST_ENG ? '0 : disp_ptr + 1'b1;
         if (coll) begin
            col_ptr   <= col_ptr == LAST_ENG ? '0 : col_ptr + 1'b1;
            coll_cnt  <= coll_cnt + 1'b1;
            pix_valid <= 1'b1;
            pix_color <= sel_color;
            pix_x     <= out_col;
            pix_y     <= out_row;
            out_col   <= out_col == 16'(LCD_W - 1) ? '0 : out_col + 1'b1;
            out_row   <= out_col == 16'(LCD_W - 1) ? out_row + 1'b1 : out_row;
         end else if (pix_ready) pix_valid <= 1'b0;
      end
endmodule

// File: doc/julia_pixel_scheduler.md
Name: julia_pixel_scheduler

Overview:
Frame-level sequencer that shares NUM_ENG Julia iteration engines across all LCD pixels.
- Walks the LCD_W x LCD_H raster and generates fixed-point (x, y) coordinates.
- Dispatches each pixel to a free engine round-robin.
- Collects colours strictly in raster order and streams them over a valid/ready port to the LCD pixel writer.
- Sits between the frame/position controller (supplies start/step values and frame_start) and the TFT write FSM.

Parameters:
NUM_ENG, 8, number of iteration engines served (2..16)
LCD_W, 320, pixels per row
LCD_H, 240, rows per frame
COORD_W, 32, signed fixed-point coordinate width (scale 8192)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; starts a frame when idle
start_x  in  COORD_W  signed x of column 0, latched on accepted frame_start
start_y  in  COORD_W  signed y of row 0, latched
dx  in  COORD_W  signed x step per column, latched
dy  in  COORD_W  signed y step per row, latched
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse after last pixel is accepted downstream
eng_enable  out  NUM_ENG  per-engine start/hold; engine resets while low
eng_x  out  NUM_ENG*COORD_W  per-engine x, stable while its enable is high
eng_y  out  NUM_ENG*COORD_W  per-engine y, stable while its enable is high
eng_end  in  NUM_ENG  engine result valid (meaningful only while enabled)
eng_color  in  NUM_ENG*16  engine RGB565 result
pix_valid  out  1  output pixel valid
pix_ready  in  1  writer accepts pixel
pix_color  out  16  RGB565 colour
pix_x  out  16  column of pix_color
pix_y  out  16  row of pix_color

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including eng_enable, eng_x/eng_y, pix_* and busy. Reset mid-frame drops every enable immediately. No state is retained.
- Top FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: frame_start=1 latches start/step values, clears counters, sets dispatch and collect pointers to 0 and busy to 1, and goes to RUN.
  - frame_start outside IDLE is ignored.
  - RUN: issues pixels until LCD_W*LCD_H have been dispatched, then goes to DRAIN.
  - DRAIN: waits until the collected count equals LCD_W*LCD_H and the output register is empty.
  - DONE: one cycle; frame_done=1, busy=0; then IDLE.
- Engine slot states (per engine): FREE -> BUSY -> COOL -> FREE.
  - Dispatch sets BUSY with enable=1.
  - Collection sets COOL with enable=0 for exactly one cycle, which guarantees the engine sees a reset.
- Dispatch (RUN): at most one pixel per cycle, always to engine disp_ptr, and only if that slot is FREE.
  - Drive eng_x/eng_y for that engine and raise enable in the same cycle.
  - disp_ptr increments modulo NUM_ENG.
  - First enable is high on the 2nd clock edge after frame_start (1-cycle latency from IDLE->RUN).
- Coordinate generation:
  - Per dispatch, col increments and cur_x += dx.
  - At col==LCD_W-1: col=0, cur_x=start_x, row++, cur_y += dy.
  - Arithmetic is two's-complement, wrapping mod 2^COORD_W; no saturation.
- Collection (in order):
  - Occurs when slot col_ptr is BUSY, eng_end[col_ptr]=1, and the output register is empty or being accepted this cycle.
  - Load pix_color and its pix_x/pix_y, set pix_valid, release the slot to COOL, and increment col_ptr modulo NUM_ENG.
  - Results from other engines wait while enabled (engine holds its end/colour).
- Output: pix_valid stays high with pix_color/pix_x/pix_y stable until pix_ready=1. Accept plus new collect in the same cycle gives back-to-back output with no bubble.
- Max outstanding pixels is NUM_ENG. With pix_ready held low, dispatch stalls once the ring is full; no result is dropped.
- A collect and a dispatch on the same engine in the same cycle is impossible: COOL blocks it.
- The last pixel has pix_x=LCD_W-1 and pix_y=LCD_H-1; frame_done follows its acceptance by 1 cycle (DONE state).

Decomposition:
- Shared package julia_pkg holds:
  - LCD_W/LCD_H defaults
  - COORD_W, the fixed-point scale constant 8192, and default START/END coordinates
  - the top FSM enum {IDLE, RUN, DRAIN, DONE} and the slot enum {FREE, BUSY, COOL}
- One sub-module, julia_coord_gen: col/row counters plus x/y accumulators with load/step/last_pixel flags.

Test Plan:
1. LCD_W=4, LCD_H=2, NUM_ENG=2; engine models with random 1-30 cycle latency; pix_ready=1. Required: 8 pixels out in order (0,0),(1,0)..(3,1), colours match the model, exactly one frame_done pulse, then busy=0.
2. start_x=-16384, dx=2048, start_y=-8192, dy=1024. Required: dispatched eng_x sequence -16384,-14336,-12288,-10240 then -16384 again; eng_y is -8192 for row 0 and -7168 for row 1.
3. Engine 1 finishes 20 cycles before engine 0. Required: pix_valid stays low until engine 0 ends; output order is engine0 then engine1; engine1 enable is held until it is collected.
4. pix_ready held low for 50 cycles mid-frame. Required: pix_* stable throughout, at most NUM_ENG enables high, no further dispatch; after release the remaining pixels arrive with none lost or duplicated.
5. frame_start pulsed while busy: ignored. rst_n low mid-frame: eng_enable=0 immediately (async) and busy=0. A new frame_start after reset runs a full correct frame.
6. Default parameters with fixed-latency engines: 76800 pixels accepted and the final pixel is (319,239); frame_done occurs 1 cycle after its acceptance.
